// File: rtl/store_coalesce_buf.sv
// Store coalescing FIFO sitting in front of a byte-masked SRAM write port.
// Optional merging into the newest entry is enabled by defining STORE_COALESCE_MERGE_EN.
module store_coalesce_buf #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ADDR_WIDTH-1:0]       in_addr,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic [DATA_WIDTH/8-1:0]     in_mask,
  input  logic                        drain_en,
  output logic                        we,
  output logic [ADDR_WIDTH-1:0]       waddr,
  output logic [DATA_WIDTH-1:0]       wdata,
  output logic [DATA_WIDTH/8-1:0]     wmask,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        empty
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int MASK_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [MASK_W-1:0]     mask_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [PTR_W-1:0] newest_s;
  logic             not_full_s;
  logic             pop_s;
  logic             merge_hit_s;
  logic             accept_s;
  logic             push_s;
  logic             merge_s;

  assign newest_s   = tail_q - PTR_W'(1);
  assign not_full_s = (count_q < CNT_W'(DEPTH));
  assign empty      = (count_q == {CNT_W{1'b0}});
  assign pop_s      = drain_en && !empty;
  assign count      = count_q;

  // The newest entry is only a merge target while it is not leaving this cycle.
`ifdef STORE_COALESCE_MERGE_EN
  assign merge_hit_s = !empty && (addr_q[newest_s] == in_addr) &&
                       !(pop_s && (newest_s == head_q));
`else
  assign merge_hit_s = 1'b0;
`endif

  assign in_ready = not_full_s || merge_hit_s;
  assign accept_s = in_valid && in_ready && !rst;
  assign push_s   = accept_s && (in_mask != {MASK_W{1'b0}}) && !merge_hit_s;
  assign merge_s  = accept_s && (in_mask != {MASK_W{1'b0}}) && merge_hit_s;

  // Write port: head entry when draining, zeros otherwise.
  always_comb begin
    we    = pop_s;
    waddr = {ADDR_WIDTH{1'b0}};
    wdata = {DATA_WIDTH{1'b0}};
    wmask = {MASK_W{1'b0}};
    if (pop_s) begin
      waddr = addr_q[head_q];
      wdata = data_q[head_q];
      wmask = mask_q[head_q];
    end else begin
      waddr = {ADDR_WIDTH{1'b0}};
    end
  end

  // Pointer and occupancy next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_s) begin
      head_d = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
    if (push_s) begin
      tail_d = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; clearing count invalidates every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage: allocate at tail, or fold masked bytes into the newest entry.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
      mask_q[tail_q] <= in_mask;
    end else if (merge_s) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (in_mask[b]) begin
          data_q[newest_s][b*8 +: 8] <= in_data[b*8 +: 8];
        end
      end
      mask_q[newest_s] <= mask_q[newest_s] | in_mask;
    end
  end

endmodule

// File: tb/tb_store_coalesce_buf.sv
// Directed bench for store_coalesce_buf: vector table plus hand-written merge/full/reset sequences.
module tb_store_coalesce_buf;

`ifdef STORE_COALESCE_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_addr;
  logic [31:0] in_data;
  logic [3:0]  in_mask;
  logic        drain_en;
  logic        we;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [2:0]  count;
  logic        empty;

  int tests  = 0;
  int failed = 0;

  store_coalesce_buf #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_mask(in_mask),
    .drain_en(drain_en),
    .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        drain;
    logic        ready;
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] m, input logic dr, input logic rdy,
                     input logic w, input logic [7:0] wa, input logic [31:0] wd,
                     input logic [3:0] wm, input logic [2:0] c);
    vec_t t;
    t.v = v; t.addr = a; t.data = d; t.mask = m; t.drain = dr;
    t.ready = rdy; t.we = w; t.waddr = wa; t.wdata = wd; t.wmask = wm; t.cnt = c;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic dr);
    in_valid = v; in_addr = a; in_data = d; in_mask = m; drain_en = dr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_port(input string tag, input logic w, input logic [7:0] wa,
                          input logic [31:0] wd, input logic [3:0] wm);
    chk({tag, ".we"},    64'(we),    64'(w));
    chk({tag, ".waddr"}, 64'(waddr), 64'(wa));
    chk({tag, ".wdata"}, 64'(wdata), 64'(wd));
    chk({tag, ".wmask"}, 64'(wmask), 64'(wm));
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    //  v     addr    data           mask  drn | rdy   we    waddr   wdata          wmask cnt
    add(1'b0, 8'h00, 32'h00000000, 4'h0, 1'b0,  1'b1, 1'b0, 8'h00, 32'h00000000, 4'h0, 3'd0);
    add(1'b1, 8'h10, 32'hAABBCCDD, 4'hF, 1'b1,  1'b1, 1'b0, 8'h00, 32'h00000000, 4'h0, 3'd0);
    add(1'b0, 8'h00, 32'h00000000, 4'h0, 1'b1,  1'b1, 1'b1, 8'h10, 32'hAABBCCDD, 4'hF, 3'd1);
    add(1'b0, 8'h00, 32'h00000000, 4'h0, 1'b1,  1'b1, 1'b0, 8'h00, 32'h00000000, 4'h0, 3'd0);
    add(1'b1, 8'h55, 32'h12345678, 4'h0, 1'b1,  1'b1, 1'b0, 8'h00, 32'h00000000, 4'h0, 3'd0);
    add(1'b0, 8'h00, 32'h00000000, 4'h0, 1'b1,  1'b1, 1'b0, 8'h00, 32'h00000000, 4'h0, 3'd0);
    add(1'b1, 8'h00, 32'h00000100, 4'hF, 1'b0,  1'b1, 1'b0, 8'h00, 32'h00000000, 4'h0, 3'd0);
    add(1'b1, 8'h01, 32'h00000101, 4'hF, 1'b0,  1'b1, 1'b0, 8'h00, 32'h00000000, 4'h0, 3'd1);
    add(1'b1, 8'h02, 32'h00000102, 4'hF, 1'b0,  1'b1, 1'b0, 8'h00, 32'h00000000, 4'h0, 3'd2);
    add(1'b1, 8'h03, 32'h00000103, 4'hF, 1'b0,  1'b1, 1'b0, 8'h00, 32'h00000000, 4'h0, 3'd3);
    add(1'b1, 8'h04, 32'h00000104, 4'hF, 1'b0,  1'b0, 1'b0, 8'h00, 32'h00000000, 4'h0, 3'd4);
    add(1'b1, 8'h04, 32'h00000104, 4'hF, 1'b1,  1'b0, 1'b1, 8'h00, 32'h00000100, 4'hF, 3'd4);
    add(1'b0, 8'h00, 32'h00000000, 4'h0, 1'b0,  1'b1, 1'b0, 8'h00, 32'h00000000, 4'h0, 3'd3);
    add(1'b0, 8'h00, 32'h00000000, 4'h0, 1'b1,  1'b1, 1'b1, 8'h01, 32'h00000101, 4'hF, 3'd3);
    add(1'b0, 8'h00, 32'h00000000, 4'h0, 1'b1,  1'b1, 1'b1, 8'h02, 32'h00000102, 4'hF, 3'd2);
    add(1'b0, 8'h00, 32'h00000000, 4'h0, 1'b1,  1'b1, 1'b1, 8'h03, 32'h00000103, 4'hF, 3'd1);
    add(1'b0, 8'h00, 32'h00000000, 4'h0, 1'b1,  1'b1, 1'b0, 8'h00, 32'h00000000, 4'h0, 3'd0);
    add(1'b1, 8'h31, 32'h00000131, 4'hF, 1'b0,  1'b1, 1'b0, 8'h00, 32'h00000000, 4'h0, 3'd0);
    add(1'b1, 8'h32, 32'h00000132, 4'hF, 1'b0,  1'b1, 1'b0, 8'h00, 32'h00000000, 4'h0, 3'd1);
    add(1'b1, 8'h30, 32'h00000130, 4'hF, 1'b1,  1'b1, 1'b1, 8'h31, 32'h00000131, 4'hF, 3'd2);
    add(1'b0, 8'h00, 32'h00000000, 4'h0, 1'b1,  1'b1, 1'b1, 8'h32, 32'h00000132, 4'hF, 3'd2);
    add(1'b0, 8'h00, 32'h00000000, 4'h0, 1'b1,  1'b1, 1'b1, 8'h30, 32'h00000130, 4'hF, 3'd1);
    add(1'b0, 8'h00, 32'h00000000, 4'h0, 1'b1,  1'b1, 1'b0, 8'h00, 32'h00000000, 4'h0, 3'd0);
    // Same address as the entry being popped: must allocate, never merge.
    add(1'b1, 8'h40, 32'h000000AA, 4'h1, 1'b0,  1'b1, 1'b0, 8'h00, 32'h00000000, 4'h0, 3'd0);
    add(1'b1, 8'h40, 32'h0000BB00, 4'h2, 1'b1,  1'b1, 1'b1, 8'h40, 32'h000000AA, 4'h1, 3'd1);
    add(1'b0, 8'h00, 32'h00000000, 4'h0, 1'b1,  1'b1, 1'b1, 8'h40, 32'h0000BB00, 4'h2, 3'd1);
    add(1'b0, 8'h00, 32'h00000000, 4'h0, 1'b1,  1'b1, 1'b0, 8'h00, 32'h00000000, 4'h0, 3'd0);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].v, vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].drain);
      chk({tag, ".in_ready"}, 64'(in_ready), 64'(vecs[i].ready));
      chk({tag, ".count"},    64'(count),    64'(vecs[i].cnt));
      chk({tag, ".empty"},    64'(empty),    64'(vecs[i].cnt == 3'd0));
      chk_port(tag, vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].wmask);
      tick();
    end

    // Merge of two partial stores to the same word while the port is busy.
    drive(1'b1, 8'h20, 32'h000000AA, 4'h1, 1'b0); tick();
    drive(1'b1, 8'h20, 32'h0000BB00, 4'h2, 1'b0); tick();
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
    chk("merge.count", 64'(count), MERGE ? 64'd1 : 64'd2);
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b1);
    chk_port("merge.w1", 1'b1, 8'h20, MERGE ? 32'h0000BBAA : 32'h000000AA, MERGE ? 4'h3 : 4'h1);
    tick();
    chk_port("merge.w2", !MERGE, MERGE ? 8'h00 : 8'h20, MERGE ? 32'h0 : 32'h0000BB00,
             MERGE ? 4'h0 : 4'h2);
    tick();
    chk("merge.count_end", 64'(count), 64'd0);

    // Full buffer: only a store hitting the newest entry may enter.
    for (int a = 0; a < 4; a++) begin
      drive(1'b1, 8'(a), 32'h00000100 + 32'(a), 4'hF, 1'b0);
      tick();
    end
    drive(1'b1, 8'h04, 32'h00000104, 4'hF, 1'b0);
    chk("full.count", 64'(count), 64'd4);
    chk("full.ready_new", 64'(in_ready), 64'd0);
    tick();
    drive(1'b1, 8'h03, 32'hFF000000, 4'h8, 1'b0);
    chk("full.ready_hit", 64'(in_ready), 64'(MERGE));
    tick();
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
    chk("full.count_after", 64'(count), 64'd4);
    for (int a = 0; a < 4; a++) begin
      drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b1);
      chk_port($sformatf("full.w%0d", a), 1'b1, 8'(a),
               (a == 3 && MERGE) ? 32'hFF000103 : 32'h00000100 + 32'(a), 4'hF);
      tick();
    end
    chk("full.empty_end", 64'(empty), 64'd1);

    // Reset mid-run drops buffered stores and ignores a concurrent request.
    for (int a = 0; a < 3; a++) begin
      drive(1'b1, 8'h60 + 8'(a), 32'h00000600 + 32'(a), 4'hF, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
    chk("rst.count_before", 64'(count), 64'd3);
    rst = 1'b1;
    drive(1'b1, 8'h70, 32'h00000700, 4'hF, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.empty", 64'(empty), 64'd1);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk_port("rst.port", 1'b0, 8'h00, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b1);
      chk($sformatf("rst.stale%0d", k), 64'(we), 64'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
